mc_mem_ctrl: RTL and testbench
==============================

MC_MEM_CTRL -- requirements
Module: mc_mem_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: rd_req  input  1  read request from the control unit (instruction fetch or lw).
REQ-004 SHALL have port: wr_req  input  1  write request from the control unit (sw, the wmem phase).
REQ-005 SHALL have port: addr  input  32  byte address from the PC/ALU mux (iord selected).
REQ-006 SHALL have port: wdata  input  32  store data.
REQ-007 SHALL have ports: rdata  output  32  registered read data; ready  output  1  one-cycle completion pulse; busy  output  1  transaction in progress; err  output  1  sticky error flag.
REQ-008 SHALL have ports: mem_en  output  1; mem_we  output  1; mem_addr  output  30  word address; mem_wdata  output  32; mem_rdata  input  32; mem_ack  input  1  external memory handshake.
REQ-009 SHALL have parameter: TIMEOUT, default 15, maximum wait cycles for mem_ack.

Function
REQ-010 SHALL implement the states IDLE, ACCESS, DONE and FAULT.
REQ-011 IDLE: a request (rd_req|wr_req) with addr[1:0]==0 SHALL do all of the following at the next edge: latch addr[31:2], wdata and the write flag (wr_req has priority if both requests are high), then go to ACCESS.
REQ-012 IDLE: a request with addr[1:0]!=0 SHALL go to FAULT with no external access.
REQ-013 ACCESS: mem_en SHALL be 1; mem_we SHALL equal the latched write flag; mem_addr and mem_wdata SHALL equal the latched values and SHALL stay stable until mem_ack.
REQ-014 ACCESS: on mem_ack=1, a read SHALL capture mem_rdata into rdata at that edge, and the block SHALL go to DONE.
REQ-015 ACCESS: a 4-bit wait counter SHALL clear on entry and increment each cycle without ack; when the counter equals TIMEOUT and there is no ack, the block SHALL go to FAULT.
REQ-016 DONE: ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE; requests in DONE SHALL be ignored.
REQ-017 FAULT: ready SHALL pulse for one cycle, err SHALL set and remain set until reset, rdata SHALL be held unchanged, and the next state SHALL be IDLE.
REQ-018 busy SHALL be 1 in ACCESS, DONE and FAULT, and 0 in IDLE; the control unit holds its state while busy=1.
REQ-019 Minimum latency: request at edge N, mem_ack in the first ACCESS cycle, ready in cycle N+2.
REQ-020 mem_ack while not in ACCESS SHALL be ignored.
REQ-021 rdata SHALL change only on a completed read; writes SHALL leave rdata unchanged.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, clear the wait counter, and set rdata=0, ready=0, busy=0, err=0, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-023 reset during ACCESS SHALL abort the transaction, with mem_en=0 in the following cycle; no ready SHALL be issued.

Structure
REQ-024 State encodings and the default TIMEOUT SHALL live in the shared CPU package alongside the control-unit state constants.
REQ-025 The block SHALL be flat: one next-state/output process and one registered process; no sub-module is needed.

Verification
REQ-026 Scenario: read at addr=0x0000_0010, mem_ack on the first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x4, ready pulses 2 cycles after the request, rdata=0xDEADBEEF, err=0.
REQ-027 Scenario: write to addr=0x20 with wdata=0x12345678, mem_ack after 3 wait cycles -> mem_we=1 and mem_wdata stable for 4 cycles, one ready pulse, rdata unchanged.
REQ-028 Scenario: read at addr=0x0000_0003 -> no mem_en, FAULT, ready pulse, err=1 and sticky across later good accesses.
REQ-029 Scenario: mem_ack never asserted, TIMEOUT=15 -> FAULT after 16 ACCESS cycles, err=1, mem_en drops.
REQ-030 Scenario: rd_req and wr_req both high -> write performed; reset asserted mid-ACCESS -> all outputs 0 next cycle, no ready pulse.
REQ-031 Scenario: stray mem_ack in IDLE or DONE, and back-to-back requests held through DONE -> no state change and no ready from the stray ack; the held request is re-accepted only after the return to IDLE.

Source files
------------

// File: rtl/mc_mem_ctrl_pkg.sv
// Shared CPU package: memory-controller and control-unit state encodings,
// plus the default memory handshake timeout.
package mc_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MemIdle,
        MemAccess,
        MemDone,
        MemFault
    } mem_state_e;

    typedef enum logic [2:0] {
        CuFetch,
        CuDecode,
        CuExec,
        CuMem,
        CuWriteBack
    } cu_state_e;

    localparam int unsigned MemTimeoutDefault = 15;
    localparam int unsigned MemWaitWidth      = 4;

endpackage

// File: rtl/mc_mem_ctrl.sv
// Multicycle memory controller: one word access per request, aligned-address
// check, bounded wait on the external ack, and a sticky error flag.
module mc_mem_ctrl
    import mc_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = MemTimeoutDefault
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [MemWaitWidth-1:0] TimeoutCnt = MemWaitWidth'(TIMEOUT);

    mem_state_e              r_state;
    mem_state_e              w_state_d;
    logic [MemWaitWidth-1:0] r_wait;
    logic [MemWaitWidth-1:0] w_wait_d;
    logic [29:0]             r_addr;
    logic [29:0]             w_addr_d;
    logic [31:0]             r_wdata;
    logic [31:0]             w_wdata_d;
    logic                    r_we;
    logic                    w_we_d;
    logic [31:0]             r_rdata;
    logic [31:0]             w_rdata_d;
    logic                    r_err;
    logic                    w_err_d;

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_we_d    = r_we;
        w_rdata_d = r_rdata;
        w_err_d   = r_err;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        ready     = 1'b0;
        busy      = 1'b1;

        unique case (r_state)
            MemIdle: begin
                busy = 1'b0;
                if (rd_req || wr_req) begin
                    if (addr[1:0] == 2'b00) begin
                        w_state_d = MemAccess;
                        w_wait_d  = '0;
                        w_addr_d  = addr[31:2];
                        w_wdata_d = wdata;
                        w_we_d    = wr_req;
                    end else begin
                        // Misaligned: fault without touching external memory.
                        w_state_d = MemFault;
                        w_err_d   = 1'b1;
                    end
                end
            end
            MemAccess: begin
                mem_en = 1'b1;
                mem_we = r_we;
                if (mem_ack) begin
                    if (!r_we) begin
                        w_rdata_d = mem_rdata;
                    end
                    w_state_d = MemDone;
                end else if (r_wait == TimeoutCnt) begin
                    w_state_d = MemFault;
                    w_err_d   = 1'b1;
                end else begin
                    w_wait_d = r_wait + 1'b1;
                end
            end
            MemDone: begin
                ready     = 1'b1;
                w_state_d = MemIdle;
            end
            MemFault: begin
                ready     = 1'b1;
                w_state_d = MemIdle;
            end
            default: begin
                w_state_d = MemIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MemIdle;
            r_wait  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_we    <= w_we_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
        end
    end

    assign rdata     = r_rdata;
    assign err       = r_err;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mc_mem_ctrl.sv
// Directed bench for mc_mem_ctrl: inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_mc_mem_ctrl;

    logic        clock;
    logic        reset;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks;
    int n_errors;

    mc_mem_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        step();
        step();
        reset = 1'b0;

        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_ready", {31'b0, ready}, 32'h0);
        check_val("rst_busy", {31'b0, busy}, 32'h0);
        check_val("rst_err", {31'b0, err}, 32'h0);
        check_val("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check_val("rst_mem_addr", {2'b0, mem_addr}, 32'h0);

        // Aligned read, ack in the first ACCESS cycle.
        rd_req = 1'b1;
        addr   = 32'h0000_0010;
        step();
        rd_req = 1'b0;
        addr   = 32'hFFFF_FFF0;
        check_val("rd_mem_en", {31'b0, mem_en}, 32'h1);
        check_val("rd_mem_we", {31'b0, mem_we}, 32'h0);
        check_val("rd_mem_addr", {2'b0, mem_addr}, 32'h4);
        check_val("rd_busy", {31'b0, busy}, 32'h1);
        check_val("rd_ready_early", {31'b0, ready}, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check_val("rd_ready", {31'b0, ready}, 32'h1);
        check_val("rd_rdata", rdata, 32'hDEAD_BEEF);
        check_val("rd_en_drop", {31'b0, mem_en}, 32'h0);
        step();
        check_val("rd_ready_once", {31'b0, ready}, 32'h0);
        check_val("rd_idle_busy", {31'b0, busy}, 32'h0);
        check_val("rd_err", {31'b0, err}, 32'h0);

        // Write with three wait cycles before the ack.
        wr_req = 1'b1;
        addr   = 32'h0000_0020;
        wdata  = 32'h1234_5678;
        step();
        wr_req = 1'b0;
        wdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("wr_we_%0d", i), {31'b0, mem_we}, 32'h1);
            check_val($sformatf("wr_wdata_%0d", i), mem_wdata, 32'h1234_5678);
            check_val($sformatf("wr_addr_%0d", i), {2'b0, mem_addr}, 32'h8);
            check_val($sformatf("wr_noready_%0d", i), {31'b0, ready}, 32'h0);
            if (i == 3) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        check_val("wr_ready", {31'b0, ready}, 32'h1);
        check_val("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
        step();
        check_val("wr_ready_once", {31'b0, ready}, 32'h0);

        // Both requests high: the write wins.
        rd_req = 1'b1;
        wr_req = 1'b1;
        addr   = 32'h0000_0050;
        wdata  = 32'hA5A5_A5A5;
        step();
        rd_req = 1'b0;
        wr_req = 1'b0;
        check_val("both_we", {31'b0, mem_we}, 32'h1);
        check_val("both_addr", {2'b0, mem_addr}, 32'h14);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        check_val("both_ready", {31'b0, ready}, 32'h1);
        check_val("both_rdata_kept", rdata, 32'hDEAD_BEEF);
        step();

        // Stray ack in IDLE.
        mem_ack = 1'b1;
        step();
        check_val("stray_idle_busy", {31'b0, busy}, 32'h0);
        check_val("stray_idle_ready", {31'b0, ready}, 32'h0);
        check_val("stray_idle_rdata", rdata, 32'hDEAD_BEEF);
        mem_ack = 1'b0;

        // Held read request through DONE, stray ack kept high in DONE.
        rd_req    = 1'b1;
        addr      = 32'h0000_0060;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b1;
        step();
        check_val("b2b_ready1", {31'b0, ready}, 32'h1);
        check_val("b2b_rdata1", rdata, 32'h1111_1111);
        mem_rdata = 32'h9999_9999;
        step();
        mem_ack = 1'b0;
        check_val("b2b_idle_busy", {31'b0, busy}, 32'h0);
        check_val("b2b_idle_ready", {31'b0, ready}, 32'h0);
        check_val("b2b_idle_en", {31'b0, mem_en}, 32'h0);
        check_val("b2b_rdata_hold", rdata, 32'h1111_1111);
        step();
        rd_req = 1'b0;
        check_val("b2b_reaccept", {31'b0, mem_en}, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        step();
        mem_ack = 1'b0;
        check_val("b2b_ready2", {31'b0, ready}, 32'h1);
        check_val("b2b_rdata2", rdata, 32'h2222_2222);
        step();

        // Reset in the middle of ACCESS.
        wr_req = 1'b1;
        addr   = 32'h0000_0070;
        wdata  = 32'hFEED_FACE;
        step();
        wr_req = 1'b0;
        check_val("rstmid_en", {31'b0, mem_en}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rstmid_en0", {31'b0, mem_en}, 32'h0);
        check_val("rstmid_we0", {31'b0, mem_we}, 32'h0);
        check_val("rstmid_busy0", {31'b0, busy}, 32'h0);
        check_val("rstmid_ready0", {31'b0, ready}, 32'h0);
        check_val("rstmid_rdata0", rdata, 32'h0);
        check_val("rstmid_addr0", {2'b0, mem_addr}, 32'h0);
        check_val("rstmid_wdata0", mem_wdata, 32'h0);
        step();
        check_val("rstmid_noready", {31'b0, ready}, 32'h0);

        // Load a known rdata, then let a read time out.
        rd_req    = 1'b1;
        addr      = 32'h0000_0030;
        step();
        rd_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        step();
        check_val("to_pre_rdata", rdata, 32'hCAFE_F00D);
        check_val("to_pre_err", {31'b0, err}, 32'h0);
        rd_req    = 1'b1;
        addr      = 32'h0000_0040;
        mem_rdata = 32'h7777_7777;
        step();
        rd_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("to_en_%0d", i), {31'b0, mem_en}, 32'h1);
            check_val($sformatf("to_noready_%0d", i), {31'b0, ready}, 32'h0);
            step();
        end
        check_val("to_en_drop", {31'b0, mem_en}, 32'h0);
        check_val("to_ready", {31'b0, ready}, 32'h1);
        check_val("to_busy", {31'b0, busy}, 32'h1);
        step();
        check_val("to_err", {31'b0, err}, 32'h1);
        check_val("to_rdata_kept", rdata, 32'hCAFE_F00D);
        check_val("to_ready_once", {31'b0, ready}, 32'h0);

        // Misaligned read faults without an access; err is sticky.
        do_reset();
        check_val("mis_pre_err", {31'b0, err}, 32'h0);
        rd_req = 1'b1;
        addr   = 32'h0000_0003;
        step();
        rd_req = 1'b0;
        check_val("mis_no_en", {31'b0, mem_en}, 32'h0);
        check_val("mis_ready", {31'b0, ready}, 32'h1);
        check_val("mis_busy", {31'b0, busy}, 32'h1);
        step();
        check_val("mis_err", {31'b0, err}, 32'h1);
        check_val("mis_idle", {31'b0, busy}, 32'h0);
        check_val("mis_rdata", rdata, 32'h0);
        rd_req = 1'b1;
        addr   = 32'h0000_0080;
        step();
        rd_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_3333;
        step();
        mem_ack = 1'b0;
        check_val("mis_good_ready", {31'b0, ready}, 32'h1);
        check_val("mis_good_rdata", rdata, 32'h3333_3333);
        step();
        check_val("mis_err_sticky", {31'b0, err}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
